// File: rtl/memif_pkg.sv
// memif_pkg: shared states, op encoding and default widths for the memory port unit
package memif_pkg;
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 9;
    localparam int DEF_TIMEOUT_CYC = 16;
endpackage

// File: rtl/memif_timeout_ctr.sv
// memif_timeout_ctr: clear/enable cycle counter with terminal flag at TIMEOUT_CYC-1
module memif_timeout_ctr
    import memif_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic clr,
    input  logic i_clear,
    input  logic i_en,
    output logic o_term
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] r_cnt;
    // restart at 0 on reset or clear, otherwise count each enabled cycle
    always_ff @(posedge clk)
        r_cnt <= (!clr || i_clear) ? '0 : (i_en ? r_cnt + 1'b1 : r_cnt);
    assign o_term = r_cnt == CW'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/mem_port_unit.sv
// mem_port_unit: MAR/MDR owner running a req/ack handshake to variable-latency memory (optional MEMIF_TIMEOUT_EN)
module mem_port_unit
    import memif_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              mar_in,
    input  logic              mdr_in,
    input  logic              rd,
    input  logic              wr,
    output logic [ADDR_W-1:0] mar_q,
    output logic [DATA_W-1:0] mdr_q,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);
    if (TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("mem_port_unit: TIMEOUT_CYC must be >= 1");
    end

    state_t r_state, w_next;
    logic r_op, r_err;
    logic [ADDR_W-1:0] r_mar, r_addr;
    logic [DATA_W-1:0] r_mdr;
    logic w_idle, w_req, w_start, w_ack, w_tmo;

    assign w_idle  = r_state == IDLE;
    assign w_req   = r_state == REQ;
    assign w_start = w_idle && (rd || wr);
    assign w_ack   = w_req && mem_ack;

`ifdef MEMIF_TIMEOUT_EN
    logic w_term;
    memif_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_ctr (
        .clk     (clk),
        .clr     (clr),
        .i_clear (!w_req),
        .i_en    (w_req),
        .o_term  (w_term)
    );
    assign w_tmo = w_req && w_term && !mem_ack;
`else
    assign w_tmo = 1'b0;
`endif

    // state register
    always_ff @(posedge clk)
        r_state <= !clr ? IDLE : w_next;

    // next state: start from IDLE, leave REQ on ack (or timeout), DONE lasts one cycle
    always_comb begin
        w_next = r_state;
        if (w_start) w_next = REQ;
        else if (w_ack) w_next = DONE;
        else if (w_tmo || !(w_idle || w_req)) w_next = IDLE;
    end

    // MAR/MDR loads only while idle; the request address is snapshotted from the pre-load MAR
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_mar  <= '0;
            r_mdr  <= '0;
            r_addr <= '0;
            r_op   <= OP_RD;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_tmo;
            if (w_idle && mar_in) r_mar <= bus_in[ADDR_W-1:0];
            if (w_idle && mdr_in) r_mdr <= bus_in;
            else if (w_ack && r_op == OP_RD) r_mdr <= mem_rdata;
            if (w_start) begin
                r_addr <= r_mar;
                r_op   <= rd ? OP_RD : OP_WR;
            end
        end
    end

    assign mar_q     = r_mar;
    assign mdr_q     = r_mdr;
    assign busy      = w_req;
    assign done      = r_state == DONE;
    assign err       = r_err;
    assign mem_req   = w_req;
    assign mem_we    = w_req && r_op == OP_WR;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_mdr;
endmodule

// File: tb/tb_mem_port_unit.sv
// tb_mem_port_unit: table-driven, directed and random checks of mem_port_unit against a transaction-level model
module tb_mem_port_unit;
    logic clk = 1'b0, clr = 1'b0;
    logic [31:0] bus_in = '0, mem_rdata = '0;
    logic mar_in = 1'b0, mdr_in = 1'b0, rd = 1'b0, wr = 1'b0, mem_ack = 1'b0;
    logic [8:0] mar_q, mem_addr;
    logic [31:0] mdr_q, mem_wdata;
    logic busy, done, err, mem_req, mem_we;
    int n_tests = 0, n_fail = 0;
    logic [8:0] mar_m = '0;
    logic [31:0] mdr_m = '0;

    mem_port_unit #(.DATA_W(32), .ADDR_W(9), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .clr(clr), .bus_in(bus_in), .mar_in(mar_in), .mdr_in(mdr_in),
        .rd(rd), .wr(wr), .mar_q(mar_q), .mdr_q(mdr_q), .busy(busy), .done(done),
        .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic m, d;
        logic [31:0] b;
        logic r, w;
        int lat;
        logic [31:0] rdat;
        logic noise;
        logic [8:0] emar;
        logic [31:0] emdr;
    } vec_t;
    vec_t tv[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_chk(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_err"}, err, 0);
        chk({nm, "_req"}, mem_req, 0);
    endtask

    // one bus-side operation: optional loads, optional rd/wr, memory acks after lat idle REQ cycles
    task automatic txn(input logic m, input logic d, input logic [31:0] b, input logic r,
                       input logic w, input int lat, input logic [31:0] rdat, input logic noise);
        logic is_op, op_wr;
        logic [8:0] a_exp;
        logic [31:0] wd_exp;
        is_op = r | w;
        op_wr = !r && w;
        a_exp = mar_m;
        mar_in = m; mdr_in = d; bus_in = b; rd = r; wr = w;
        if (m) mar_m = b[8:0];
        if (d) mdr_m = b;
        wd_exp = mdr_m;
        step();
        mar_in = 0; mdr_in = 0; rd = 0; wr = 0;
        if (is_op) begin
            for (int i = 0; i <= lat; i++) begin
                chk("req", mem_req, 1);
                chk("busy", busy, 1);
                chk("addr", mem_addr, a_exp);
                chk("we", mem_we, op_wr);
                if (op_wr) chk("wdata", mem_wdata, wd_exp);
                chk("early_done", done, 0);
                if (noise) begin
                    mar_in = 1; mdr_in = 1; bus_in = 32'hFFFF_FFFF; rd = 1; wr = 1;
                end
                if (i == lat) begin
                    mem_ack = 1; mem_rdata = rdat;
                end
                step();
                mar_in = 0; mdr_in = 0; rd = 0; wr = 0; mem_ack = 0; mem_rdata = $urandom;
            end
            if (!op_wr) mdr_m = rdat;
            chk("done", done, 1);
            chk("done_busy", busy, 0);
            chk("done_req", mem_req, 0);
            chk("done_err", err, 0);
            rd = noise;
            step();
            rd = 0;
            idle_chk("after");
        end
        chk("mar", mar_q, mar_m);
        chk("mdr", mdr_q, mdr_m);
    endtask

    initial begin
        tv[0] = '{1'b1, 1'b0, 32'h0000_01A5, 1'b0, 1'b0, 0, 32'h0, 1'b0, 9'h1A5, 32'h0};
        tv[1] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 2, 32'hDEAD_BEEF, 1'b0, 9'h1A5, 32'hDEAD_BEEF};
        tv[2] = '{1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 0, 32'h0, 1'b0, 9'h1A5, 32'h1234_5678};
        tv[3] = '{1'b1, 1'b0, 32'h0000_0010, 1'b0, 1'b0, 0, 32'h0, 1'b0, 9'h010, 32'h1234_5678};
        tv[4] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 0, 32'h5555_5555, 1'b0, 9'h010, 32'h1234_5678};
        tv[5] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1, 32'hCAFE_F00D, 1'b1, 9'h010, 32'hCAFE_F00D};
        tv[6] = '{1'b1, 1'b0, 32'hFFFF_FE33, 1'b1, 1'b0, 0, 32'h0BAD_C0DE, 1'b0, 9'h033, 32'h0BAD_C0DE};

        step();
        step();
        chk("rst_mar", mar_q, 0);
        chk("rst_mdr", mdr_q, 0);
        chk("rst_we", mem_we, 0);
        idle_chk("rst");
        clr = 1;

        for (int i = 0; i < 7; i++) begin
            txn(tv[i].m, tv[i].d, tv[i].b, tv[i].r, tv[i].w, tv[i].lat, tv[i].rdat, tv[i].noise);
            chk("tv_mar", mar_q, tv[i].emar);
            chk("tv_mdr", mdr_q, tv[i].emdr);
        end

        mem_ack = 1; mem_rdata = 32'hAAAA_AAAA;
        step();
        mem_ack = 0;
        idle_chk("spur");
        chk("spur_mdr", mdr_q, 32'h0BAD_C0DE);
        step();
        chk("spur_done2", done, 0);

        rd = 1;
        step();
        rd = 0;
        chk("rst_mid_req", mem_req, 1);
        clr = 0;
        step();
        clr = 1;
        chk("rst_mid_req_drop", mem_req, 0);
        chk("rst_mid_mar", mar_q, 0);
        chk("rst_mid_mdr", mdr_q, 0);
        mem_ack = 1; mem_rdata = 32'h7777_7777;
        step();
        mem_ack = 0;
        idle_chk("late_ack");
        chk("late_ack_mdr", mdr_q, 0);
        step();
        idle_chk("late_ack2");
        mar_m = '0;
        mdr_m = '0;

`ifdef MEMIF_TIMEOUT_EN
        txn(1'b0, 1'b1, 32'h0102_0304, 1'b0, 1'b0, 0, 32'h0, 1'b0);
        rd = 1;
        step();
        rd = 0;
        for (int i = 0; i < 4; i++) begin
            chk("tmo_req", mem_req, 1);
            chk("tmo_err_early", err, 0);
            step();
        end
        chk("tmo_err", err, 1);
        chk("tmo_done", done, 0);
        chk("tmo_busy", busy, 0);
        chk("tmo_req_drop", mem_req, 0);
        chk("tmo_mdr", mdr_q, 32'h0102_0304);
        step();
        idle_chk("tmo_after");
        txn(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 3, 32'h4444_4444, 1'b0);
`else
        rd = 1;
        step();
        rd = 0;
        for (int i = 0; i < 20; i++) step();
        chk("wait_req", mem_req, 1);
        chk("wait_busy", busy, 1);
        chk("wait_err", err, 0);
        mem_ack = 1; mem_rdata = 32'h4444_4444;
        step();
        mem_ack = 0;
        chk("wait_done", done, 1);
        chk("wait_mdr", mdr_q, 32'h4444_4444);
        mdr_m = 32'h4444_4444;
        step();
`endif

        for (int k = 0; k < 40; k++) begin
            logic r, w, m, d, n;
            logic [1:0] sel;
            sel = 2'($urandom_range(0, 3));
            r = sel[0];
            w = sel[1];
            m = 1'($urandom_range(0, 1));
            d = !(r || w) && 1'($urandom_range(0, 1));
            n = 1'($urandom_range(0, 1));
            txn(m, d, $urandom, r, w, int'($urandom_range(0, 3)), $urandom, n);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_unit.md
Name: mem_port_unit

Overview:
- Parametrised successor to the datapath's fixed 32-bit MAR/MDR/RAM path.
- Owns the MAR and MDR registers and runs a multi-cycle request/acknowledge handshake to an external memory of any latency.
- Sits between the datapath bus and the memory chip. The datapath sequencer issues read/write pulses and waits for done, instead of assuming single-cycle RAM.

Parameters:
DATA_W, 32, width of bus, MDR and memory data
ADDR_W, 9, width of MAR/memory address (MAR loads bus_in[ADDR_W-1:0])
TIMEOUT_CYC, 16, cycles waited for mem_ack before abort (used only with MEMIF_TIMEOUT_EN; must be >=1)

Ports:
clk  in  1  clock, all state on rising edge
clr  in  1  synchronous active-low reset
bus_in  in  DATA_W  datapath bus value
mar_in  in  1  load MAR from bus_in[ADDR_W-1:0]
mdr_in  in  1  load MDR from bus_in
rd  in  1  start read pulse
wr  in  1  start write pulse
mar_q  out  ADDR_W  MAR contents
mdr_q  out  DATA_W  MDR contents (to bus mux, always driven, no tristate)
busy  out  1  transaction in progress
done  out  1  one-cycle completion pulse
err  out  1  one-cycle abort pulse (tied 0 without MEMIF_TIMEOUT_EN)
mem_req  out  1  request to memory
mem_we  out  1  1=write, 0=read; valid while mem_req
mem_addr  out  ADDR_W  request address
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data, valid with mem_ack
mem_ack  in  1  memory acknowledge, one cycle

Behaviour:
- Reset (clr=0 at a clk edge):
  - MAR and MDR clear to 0; state IDLE.
  - busy, done, err, mem_req and mem_we are 0.
  - Reset mid-transaction: mem_req drops on the same edge, no done/err, the late mem_ack is ignored.
- States: IDLE, REQ, DONE.
- IDLE:
  - mar_in/mdr_in load on the edge; both may assert together.
  - rd=1: latch op=read and go to REQ.
  - wr=1 (rd=0): latch op=write and go to REQ.
  - rd and wr together: read wins, write is dropped.
  - rd/wr with mar_in in the same cycle: the request uses the OLD MAR. The new MAR is visible from the next cycle.
- REQ:
  - mem_req=1 and busy=1.
  - mem_addr=MAR, mem_we=op, mem_wdata=MDR; all held stable until ack.
  - On mem_ack:
    - Read: MDR <= mem_rdata.
    - Write: MDR unchanged.
    - Go to DONE; mem_req drops the cycle after ack.
  - Minimum latency: rd at cycle 0, REQ at 1. If ack at cycle 1, done=1 at cycle 2 and mdr_q valid at cycle 2.
- DONE: done=1 for one cycle, busy=0, return to IDLE. rd/wr in DONE is ignored.
- While busy:
  - mar_in, mdr_in, rd and wr are ignored.
  - MAR/MDR are frozen, except the read capture.
- mem_ack outside REQ is ignored.
- mar_q/mdr_q are pure register outputs, with no combinational path from inputs.
- Widths: bus_in upper bits above ADDR_W are discarded on the MAR load. mem_rdata is captured full width.

Optional Feature:
- MEMIF_TIMEOUT_EN defined:
  - A counter starts at 0 on entering REQ and increments each REQ cycle.
  - If the count reaches TIMEOUT_CYC-1 without mem_ack: mem_req drops, err=1 for one cycle, done stays 0, MDR is unchanged, return to IDLE.
  - Ack on the final cycle wins over timeout.
- Undefined: no counter; REQ waits indefinitely; err is constant 0.

Decomposition:
- Package memif_pkg holds:
  - state enum (IDLE, REQ, DONE);
  - op encoding constants (OP_RD=0, OP_WR=1);
  - default width constants.
- One sub-module, memif_timeout_ctr: clear/enable counter with terminal flag. Instantiated only under MEMIF_TIMEOUT_EN.

Test Plan:
- Reset then mar_in with bus_in=0x0000_01A5, rd; memory acks 3 cycles later with 0xDEAD_BEEF -> mem_addr=0x1A5, mem_we=0 held; done one cycle after ack; mdr_q=0xDEAD_BEEF.
- mdr_in with 0x1234_5678, mar_in 0x010, wr; ack on first REQ cycle -> mem_wdata=0x1234_5678, mem_we=1, done at cycle 2, MDR unchanged.
- rd and wr together -> only a read is issued. mdr_in=0xFFFF_FFFF while busy -> MDR keeps the read data.
- clr=0 during REQ, then ack arrives -> mem_req=0 on that edge; no done; MAR=MDR=0.
- MEMIF_TIMEOUT_EN, TIMEOUT_CYC=4, no ack -> err pulse after 4 REQ cycles; mdr_q unchanged; busy=0. Ack on cycle 4 instead -> done, not err.
- Spurious mem_ack in IDLE with mem_rdata=0xAAAA_AAAA -> MDR unchanged, no done.
